// File: rtl/trace_dots_render.sv
// Bird-trace renderer: ring buffer of the last DOTS samples, per-frame snapshot, pixel hit test.
// Optional age-based dimming is built when TRACE_FADE_EN is defined.
module trace_dots_render #(
    parameter int           DOTS            = 8,
    parameter int           DOT_SIZE        = 4,
    parameter logic [7:0]   TRACE_COLOR     = 8'hFF,
    parameter logic [7:0]   TRACE_DIM_COLOR = 8'h92
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               sample_valid,
    input  logic signed [10:0] sampleX,
    input  logic signed [10:0] sampleY,
    input  logic               clear,
    input  logic [10:0]        pixelX,
    input  logic [10:0]        pixelY,
    output logic               drawingRequest,
    output logic [7:0]         RGBout,
    output logic [3:0]         dotCount
);

    localparam logic [3:0]        LP_LAST = 4'(DOTS - 1);
    localparam logic [3:0]        LP_FULL = 4'(DOTS);
    localparam logic signed [11:0] LP_EDGE = 12'(DOT_SIZE - 1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;

    state_t             r_state;
    logic [3:0]         r_wr_ptr;
    logic [3:0]         r_count;
    logic [3:0]         r_snap_cnt;
    logic signed [10:0] r_x      [DOTS];
    logic signed [10:0] r_y      [DOTS];
    logic signed [10:0] r_snap_x [DOTS];
    logic signed [10:0] r_snap_y [DOTS];
`ifdef TRACE_FADE_EN
    logic [3:0]         r_snap_wr;
`endif
    logic               r_draw;
    logic [7:0]         r_rgb;

    logic [DOTS-1:0]    w_hit;
    logic               w_any;
    logic               w_bright;
    logic [7:0]         w_color;
    logic signed [11:0] w_px;
    logic signed [11:0] w_py;

    assign w_px = signed'({1'b0, pixelX});
    assign w_py = signed'({1'b0, pixelY});

    always_comb begin
        logic signed [11:0] v_sx;
        logic signed [11:0] v_sy;
`ifdef TRACE_FADE_EN
        int v_age;
        v_age    = 0;
        w_bright = 1'b0;
`else
        w_bright = 1'b1;
`endif
        w_hit = '0;
        v_sx  = '0;
        v_sy  = '0;
        for (int unsigned i = 0; i < DOTS; i++) begin
            v_sx = {r_snap_x[i][10], r_snap_x[i]};
            v_sy = {r_snap_y[i][10], r_snap_y[i]};
            if ((4'(i) < r_snap_cnt) &&
                (w_px >= v_sx) && (w_px <= v_sx + LP_EDGE) &&
                (w_py >= v_sy) && (w_py <= v_sy + LP_EDGE))
                w_hit[i] = 1'b1;
`ifdef TRACE_FADE_EN
            // Any young hit means the youngest hit is young, so bright wins overlaps.
            v_age = (int'(r_snap_wr) + DOTS - 1 - int'(i)) % DOTS;
            if (w_hit[i] && (v_age < DOTS / 2))
                w_bright = 1'b1;
`endif
        end
        w_any   = |w_hit;
        w_color = w_bright ? TRACE_COLOR : TRACE_DIM_COLOR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= EMPTY;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_snap_cnt <= '0;
`ifdef TRACE_FADE_EN
            r_snap_wr  <= '0;
`endif
            r_draw     <= 1'b0;
            r_rgb      <= '0;
            for (int unsigned i = 0; i < DOTS; i++) begin
                r_x[i]      <= '0;
                r_y[i]      <= '0;
                r_snap_x[i] <= '0;
                r_snap_y[i] <= '0;
            end
        end else begin
            // Snapshot samples the pre-update buffer, so same-cycle writes show next frame.
            if (startOfFrame) begin
                for (int unsigned i = 0; i < DOTS; i++) begin
                    r_snap_x[i] <= r_x[i];
                    r_snap_y[i] <= r_y[i];
                end
                r_snap_cnt <= r_count;
`ifdef TRACE_FADE_EN
                r_snap_wr  <= r_wr_ptr;
`endif
            end

            if (clear) begin
                r_wr_ptr <= '0;
                r_count  <= '0;
                r_state  <= EMPTY;
            end else if (sample_valid) begin
                for (int unsigned i = 0; i < DOTS; i++) begin
                    if (4'(i) == r_wr_ptr) begin
                        r_x[i] <= sampleX;
                        r_y[i] <= sampleY;
                    end
                end
                r_wr_ptr <= (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + 4'd1;
                case (r_state)
                    EMPTY: begin
                        r_count <= 4'd1;
                        r_state <= FILLING;
                    end
                    FILLING: begin
                        r_count <= r_count + 4'd1;
                        if (r_count == LP_FULL - 4'd1)
                            r_state <= FULL;
                    end
                    default: begin
                        r_count <= LP_FULL;
                        r_state <= FULL;
                    end
                endcase
            end

            r_draw <= w_any;
            r_rgb  <= w_any ? w_color : '0;
        end
    end

    assign drawingRequest = r_draw;
    assign RGBout         = r_rgb;
    assign dotCount       = r_count;

endmodule

// File: tb/tb_trace_dots_render.sv
// Directed, table-driven bench for trace_dots_render (expects default parameters).
// Dim-colour expectations follow TRACE_FADE_EN when it is defined.
module tb_trace_dots_render;

    logic               clk          = 1'b0;
    logic               reset        = 1'b1;
    logic               startOfFrame = 1'b0;
    logic               sample_valid = 1'b0;
    logic               clear        = 1'b0;
    logic signed [10:0] sampleX      = '0;
    logic signed [10:0] sampleY      = '0;
    logic [10:0]        pixelX       = '0;
    logic [10:0]        pixelY       = '0;
    logic               drawingRequest;
    logic [7:0]         RGBout;
    logic [3:0]         dotCount;

    localparam logic [7:0] BRT = 8'hFF;
`ifdef TRACE_FADE_EN
    localparam logic [7:0] DIM = 8'h92;
`else
    localparam logic [7:0] DIM = 8'hFF;
`endif

    trace_dots_render #(
        .DOTS            (8),
        .DOT_SIZE        (4),
        .TRACE_COLOR     (8'hFF),
        .TRACE_DIM_COLOR (8'h92)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .sample_valid   (sample_valid),
        .sampleX        (sampleX),
        .sampleY        (sampleY),
        .clear          (clear),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .drawingRequest (drawingRequest),
        .RGBout         (RGBout),
        .dotCount       (dotCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         phase;
        int         px;
        int         py;
        logic       d;
        logic [7:0] rgb;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input logic d, input logic [7:0] rgb, input string tag);
        pixelX = 11'(x);
        pixelY = 11'(y);
        step();
        chk($sformatf("%s draw(%0d,%0d)", tag, x, y), 32'(drawingRequest), 32'(d));
        chk($sformatf("%s rgb(%0d,%0d)", tag, x, y), 32'(RGBout), 32'(rgb));
    endtask

    task automatic run_phase(input int ph);
        foreach (tbl[k])
            if (tbl[k].phase == ph)
                pix(tbl[k].px, tbl[k].py, tbl[k].d, tbl[k].rgb, $sformatf("ph%0d", ph));
    endtask

    task automatic samp(input int x, input int y);
        sampleX      = 11'(x);
        sampleY      = 11'(y);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    task automatic clr();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic add(input int ph, input int x, input int y, input logic d, input logic [7:0] rgb);
        vec_t v;
        v.phase = ph; v.px = x; v.py = y; v.d = d; v.rgb = rgb;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // single dot at (100,200)
        add(2, 101, 202, 1'b1, BRT); add(2, 104, 200, 1'b0, 8'h00);
        add(2, 100, 200, 1'b1, BRT); add(2, 103, 203, 1'b1, BRT);
        add(2,  99, 200, 1'b0, 8'h00); add(2, 100, 204, 1'b0, 8'h00);
        add(2, 103, 199, 1'b0, 8'h00);
        // ring wrap: x=20..90 present, newest four bright
        add(3, 20, 50, 1'b1, DIM); add(3, 23, 53, 1'b1, DIM);
        add(3, 50, 52, 1'b1, DIM); add(3, 60, 50, 1'b1, BRT);
        add(3, 90, 50, 1'b1, BRT); add(3, 93, 53, 1'b1, BRT);
        add(3,  0, 50, 1'b0, 8'h00); add(3, 10, 50, 1'b0, 8'h00);
        add(3, 13, 53, 1'b0, 8'h00); add(3, 24, 50, 1'b0, 8'h00);
        add(3, 94, 50, 1'b0, 8'h00); add(3, 90, 54, 1'b0, 8'h00);
        add(4, 300, 300, 1'b0, 8'h00);
        add(5, 300, 300, 1'b1, BRT); add(5, 303, 303, 1'b1, BRT);
        add(6, 400, 100, 1'b1, BRT);
        add(7, 410, 100, 1'b1, BRT); add(7, 423, 103, 1'b1, BRT);
        add(8, 400, 100, 1'b0, 8'h00); add(8, 420, 100, 1'b0, 8'h00);
        add(9, 500, 500, 1'b0, 8'h00);
        add(10, 240, 400, 1'b1, BRT);
        add(11, 240, 400, 1'b0, 8'h00); add(11, 200, 400, 1'b0, 8'h00);
        add(12, 0, 0, 1'b1, BRT); add(12, 1, 1, 1'b1, BRT);
        add(12, 2, 2, 1'b0, 8'h00); add(12, 639, 479, 1'b1, BRT);
        add(12, 637, 479, 1'b0, 8'h00);

        // 1: reset state, empty frame sweep
        #12;
        chk("reset draw", 32'(drawingRequest), 32'd0);
        chk("reset rgb", 32'(RGBout), 32'd0);
        chk("reset dotCount", 32'(dotCount), 32'd0);
        step();
        reset = 1'b0;
        sof();
        for (int i = 0; i < 16; i++)
            pix(i * 40, i * 30, 1'b0, 8'h00, "sweep");
        chk("sweep dotCount", 32'(dotCount), 32'd0);

        // 2: one dot, edges
        samp(100, 200);
        chk("t2 dotCount", 32'(dotCount), 32'd1);
        sof();
        run_phase(2);

        // 3: ten samples into an eight-deep ring
        clr();
        for (int i = 0; i < 10; i++)
            samp(i * 10, 50);
        sof();
        chk("t3 dotCount", 32'(dotCount), 32'd8);
        run_phase(3);

        // 4: sample coincident with startOfFrame
        clr();
        sampleX = 11'(300); sampleY = 11'(300);
        sample_valid = 1'b1; startOfFrame = 1'b1;
        step();
        sample_valid = 1'b0; startOfFrame = 1'b0;
        run_phase(4);
        sof();
        run_phase(5);
        chk("t4 dotCount", 32'(dotCount), 32'd1);

        // 5: clear mid-frame keeps the snapshot until the next frame
        clr();
        samp(400, 100); samp(410, 100); samp(420, 100);
        sof();
        run_phase(6);
        clr();
        chk("t5 dotCount after clear", 32'(dotCount), 32'd0);
        run_phase(7);
        sof();
        run_phase(8);
        clear = 1'b1; sample_valid = 1'b1;
        sampleX = 11'(500); sampleY = 11'(500);
        step();
        clear = 1'b0; sample_valid = 1'b0;
        chk("t5 clear beats sample", 32'(dotCount), 32'd0);
        sof();
        run_phase(9);

        // 6: asynchronous reset mid-frame
        for (int i = 0; i < 5; i++)
            samp(200 + i * 10, 400);
        chk("t6 dotCount", 32'(dotCount), 32'd5);
        sof();
        run_phase(10);
        #2;
        reset = 1'b1;
        #1;
        chk("t6 async draw", 32'(drawingRequest), 32'd0);
        chk("t6 async rgb", 32'(RGBout), 32'd0);
        chk("t6 async dotCount", 32'(dotCount), 32'd0);
        step();
        reset = 1'b0;
        sof();
        run_phase(11);

        // negative and off-screen anchors clip without wrapping
        samp(-2, -2);
        samp(638, 478);
        sof();
        run_phase(12);
        chk("t6 clip dotCount", 32'(dotCount), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
